// File: rtl/paddle_encoder.sv
// Quadrature paddle front-end: per-phase debounce, quadrature step decode and
// a saturating paddle position with a synchronous recentre request.
module paddle_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int POS_WIDTH       = 9,
    parameter int POS_MIN         = 0,
    parameter int POS_MAX         = 400,
    parameter int POS_INIT        = 200,
    parameter int STEP            = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_in,
    input  logic                 b_in,
    input  logic                 center,
    output logic [POS_WIDTH-1:0] pos,
    output logic                 step_up,
    output logic                 step_down,
    output logic                 err
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int XW = POS_WIDTH + 1;

    localparam logic [CW-1:0]        CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [XW-1:0]        MAX_X    = XW'(POS_MAX);
    localparam logic [XW-1:0]        STEP_X   = XW'(STEP);
    localparam logic [XW-1:0]        FLOOR_X  = XW'(POS_MIN + STEP);
    localparam logic [POS_WIDTH-1:0] MIN_P    = POS_WIDTH'(POS_MIN);
    localparam logic [POS_WIDTH-1:0] MAX_P    = POS_WIDTH'(POS_MAX);
    localparam logic [POS_WIDTH-1:0] INIT_P   = POS_WIDTH'(POS_INIT);
    localparam logic [POS_WIDTH-1:0] STEP_P   = POS_WIDTH'(STEP);

    // Returns {filtered, counter}: the filter flips only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples.
    function automatic logic [CW:0] debounce_next(
        input logic          raw,
        input logic          db,
        input logic [CW-1:0] cnt
    );
        logic [CW:0] res;
        if (raw == db) begin
            res = {db, {CW{1'b0}}};
        end else if (cnt == CNT_LAST) begin
            res = {raw, {CW{1'b0}}};
        end else begin
            res = {db, cnt + CW'(1)};
        end
        return res;
    endfunction

    // Returns {up, down} for a single-bit Gray transition prev -> cur.
    function automatic logic [1:0] quad_dir(
        input logic [1:0] prev,
        input logic [1:0] cur
    );
        logic [1:0] dir;
        case ({prev, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: dir = 2'b10;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: dir = 2'b01;
            default:                                 dir = 2'b00;
        endcase
        return dir;
    endfunction

    logic                 a_db_r, b_db_r;
    logic [CW-1:0]        a_cnt_r, b_cnt_r;
    logic [1:0]           prev_r;
    logic [POS_WIDTH-1:0] pos_r;
    logic                 step_up_r, step_down_r, err_r;

    logic                 a_db_s, b_db_s;
    logic [CW-1:0]        a_cnt_s, b_cnt_s;
    logic [1:0]           cur_s;
    logic                 up_s, down_s, err_s;
    logic [XW-1:0]        sum_s;
    logic [POS_WIDTH-1:0] pos_s;

    // Debounce next-state for both phases.
    always_comb begin
        {a_db_s, a_cnt_s} = debounce_next(a_in, a_db_r, a_cnt_r);
        {b_db_s, b_cnt_s} = debounce_next(b_in, b_db_r, b_cnt_r);
    end

    // Decode filtered phases and compute the saturating next position.
    always_comb begin
        cur_s           = {a_db_r, b_db_r};
        {up_s, down_s}  = quad_dir(prev_r, cur_s);
        err_s           = ((prev_r ^ cur_s) == 2'b11);
        sum_s           = {1'b0, pos_r} + STEP_X;
        if (center) begin
            pos_s = INIT_P;
        end else if (up_s) begin
            pos_s = (sum_s > MAX_X) ? MAX_P : sum_s[POS_WIDTH-1:0];
        end else if (down_s) begin
            // Compare before subtracting so the floor never wraps.
            pos_s = ({1'b0, pos_r} < FLOOR_X) ? MIN_P : (pos_r - STEP_P);
        end else begin
            pos_s = pos_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_db_r      <= 1'b0;
            b_db_r      <= 1'b0;
            a_cnt_r     <= {CW{1'b0}};
            b_cnt_r     <= {CW{1'b0}};
            prev_r      <= 2'b00;
            pos_r       <= INIT_P;
            step_up_r   <= 1'b0;
            step_down_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            a_db_r      <= a_db_s;
            b_db_r      <= b_db_s;
            a_cnt_r     <= a_cnt_s;
            b_cnt_r     <= b_cnt_s;
            prev_r      <= cur_s;
            pos_r       <= pos_s;
            step_up_r   <= up_s;
            step_down_r <= down_s;
            err_r       <= err_s;
        end
    end

    assign pos       = pos_r;
    assign step_up   = step_up_r;
    assign step_down = step_down_r;
    assign err       = err_r;

endmodule

// File: tb/tb_paddle_encoder.sv
// Scoreboard bench for paddle_encoder: stimulus pushes expected events
// (kind, position, edge number); a negedge monitor pops and compares.
module tb_paddle_encoder;

    localparam int DEB  = 4;
    localparam int PW   = 9;
    localparam int MIN  = 0;
    localparam int MAX  = 20;
    localparam int INIT = 10;
    localparam int STP  = 4;

    localparam logic [2:0] K_UP = 3'b100;
    localparam logic [2:0] K_DN = 3'b010;
    localparam logic [2:0] K_ER = 3'b001;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          a_in = 1'b1;
    logic          b_in = 1'b1;
    logic          center = 1'b0;
    logic [PW-1:0] pos;
    logic          step_up, step_down, err;

    typedef struct {
        logic [2:0] kind;
        int         pos;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    paddle_encoder #(
        .DEBOUNCE_CYCLES(DEB), .POS_WIDTH(PW), .POS_MIN(MIN),
        .POS_MAX(MAX), .POS_INIT(INIT), .STEP(STP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .a_in(a_in), .b_in(b_in),
        .center(center), .pos(pos), .step_up(step_up),
        .step_down(step_down), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, want, cyc);
    endtask

    // Drive a new AB pair at a negedge; the event registers 5 edges later.
    task automatic drive(input logic a, input logic b, input logic [2:0] kind, input int p);
        exp_t e;
        @(negedge clk);
        a_in = a;
        b_in = b;
        e.kind = kind; e.pos = p; e.cyc = cyc + DEB + 1;
        q.push_back(e);
        repeat (10) @(negedge clk);
    endtask

    // Monitor: any pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (step_up || step_down || err)) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", int'({step_up, step_down, err}), 0);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", int'({step_up, step_down, err}), int'(e.kind));
                chk("pulse_pos", int'(pos), e.pos);
                chk("pulse_edge", cyc, e.cyc);
            end
        end
    end

    initial begin
        exp_t e;
        // Reset with both phases high.
        repeat (3) @(negedge clk);
        chk("reset_pos", int'(pos), INIT);
        chk("reset_up", int'(step_up), 0);
        chk("reset_dn", int'(step_down), 0);
        chk("reset_err", int'(err), 0);
        reset_n = 1'b1;
        e.kind = K_ER; e.pos = 10; e.cyc = cyc + DEB + 1;
        q.push_back(e);
        repeat (10) @(negedge clk);

        // Back to 00: both phases flip together again.
        drive(1'b0, 1'b0, K_ER, 10);

        // Forward quadrature into the ceiling.
        drive(1'b0, 1'b1, K_UP, 14);
        drive(1'b1, 1'b1, K_UP, 18);
        drive(1'b1, 1'b0, K_UP, 20);
        drive(1'b0, 1'b0, K_UP, 20);

        // Recentre without any step.
        @(negedge clk); center = 1'b1;
        @(negedge clk); center = 1'b0;
        chk("center_pos", int'(pos), 10);

        // Reverse into the floor.
        drive(1'b1, 1'b0, K_DN, 6);
        drive(1'b1, 1'b1, K_DN, 2);
        drive(1'b0, 1'b1, K_DN, 0);
        drive(1'b0, 1'b0, K_DN, 0);
        drive(1'b1, 1'b0, K_DN, 0);

        // Back to 00 (up), then a 3-sample glitch on A.
        drive(1'b0, 1'b0, K_UP, 4);
        @(negedge clk); a_in = 1'b1;
        repeat (3) @(negedge clk);
        a_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_pos", int'(pos), 4);
        drive(1'b1, 1'b0, K_DN, 0);

        // center in the same cycle the step_up registers.
        @(negedge clk);
        a_in = 1'b0; b_in = 1'b0;
        e.kind = K_UP; e.pos = 10; e.cyc = cyc + DEB + 1;
        q.push_back(e);
        repeat (4) @(negedge clk);
        center = 1'b1;
        @(negedge clk);
        center = 1'b0;
        repeat (5) @(negedge clk);
        chk("collide_pos", int'(pos), 10);

        // Async reset while A is mid-debounce.
        drive(1'b0, 1'b1, K_UP, 14);
        @(negedge clk); a_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_pos", int'(pos), 14);
        reset_n = 1'b0;
        #1;
        chk("async_pos", int'(pos), INIT);
        chk("async_up", int'(step_up), 0);
        a_in = 1'b0; b_in = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_pos", int'(pos), INIT);

        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
